// File: rtl/encoder_rpm_sched.sv
// Multi-channel encoder edge counter with gated snapshots, served round-robin
// to one shared count-to-RPM scaler over a req/ack handshake.

module encoder_rpm_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             term,
  output logic [CNT_W-1:0] snap
);
  logic             sync1_q, sync2_q, prev_q, edge_det;
  logic [CNT_W-1:0] cnt_d, cnt_q, snap_d, snap_q;

  always_comb begin
    edge_det = sync2_q & ~prev_q;
    snap_d   = term ? cnt_q : snap_q;
    cnt_d    = cnt_q;
    // an edge landing on the terminal cycle belongs to the new window
    if (term)                         cnt_d = edge_det ? CNT_W'(1) : '0;
    else if (edge_det && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      snap_q  <= '0;
    end else begin
      sync1_q <= tick;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
    end
  end

  assign snap = snap_q;
endmodule

module encoder_rpm_sched #(
  parameter int NCH         = 4,
  parameter int GATE_CYCLES = 6250000,
  parameter int CNT_W       = 16,
  parameter int RPM_W       = 10,
  parameter int TIMEOUT     = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           ticks,
  output logic                     scale_req,
  output logic [$clog2(NCH)-1:0]   scale_ch,
  output logic [CNT_W-1:0]         scale_cnt,
  input  logic                     scale_ack,
  input  logic [RPM_W-1:0]         scale_rpm,
  output logic [NCH*RPM_W-1:0]     rpm,
  output logic [NCH-1:0]           rpm_valid,
  output logic [NCH-1:0]           overrun,
  output logic [NCH-1:0]           tmo_err
);
  localparam int CH_W  = $clog2(NCH);
  localparam int IDX_W = CH_W + 1;
  localparam int TM_W  = $clog2(GATE_CYCLES);
  localparam int WT_W  = $clog2(TIMEOUT + 1);
  localparam logic [TM_W-1:0]  GATE_LAST = TM_W'(GATE_CYCLES - 1);
  localparam logic [WT_W-1:0]  TMO_LAST  = WT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] NCH_L     = IDX_W'(NCH);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NCH - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                       state_d, state_q;
  logic [TM_W-1:0]              timer_d, timer_q;
  logic [WT_W-1:0]              wait_d, wait_q;
  logic [CH_W-1:0]              ptr_d, ptr_q, ch_d, ch_q, pick_ch;
  logic [CNT_W-1:0]             cnt_req_d, cnt_req_q;
  logic                         req_d, req_q;
  logic [NCH-1:0]               pending_d, pending_q;
  logic [NCH-1:0]               overrun_d, overrun_q, tmo_d, tmo_q;
  logic [NCH-1:0]               rpm_valid_d, rpm_valid_q;
  logic [NCH-1:0][RPM_W-1:0]    rpm_d, rpm_q;
  logic [NCH-1:0][CNT_W-1:0]    snap;
  logic [IDX_W-1:0]             idx;
  logic                         term, pick_ok, ack_hit;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    encoder_rpm_lane #(.CNT_W(CNT_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (ticks[k]),
      .term (term),
      .snap (snap[k])
    );
  end

  always_comb begin
    term    = (timer_q == GATE_LAST);
    timer_d = term ? '0 : timer_q + 1'b1;

    // scan downward so the last hit is the first pending channel at/after ptr
    pick_ok = 1'b0;
    pick_ch = ptr_q;
    idx     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + IDX_W'(i);
      if (idx >= NCH_L) idx = idx - NCH_L;
      if (pending_q[idx[CH_W-1:0]]) begin
        pick_ok = 1'b1;
        pick_ch = idx[CH_W-1:0];
      end
    end

    ack_hit     = (state_q == S_BUSY) && scale_ack;
    state_d     = state_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    cnt_req_d   = cnt_req_q;
    req_d       = req_q;
    wait_d      = wait_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    tmo_d       = tmo_q;
    rpm_d       = rpm_q;
    rpm_valid_d = '0;

    case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          ch_d      = pick_ch;
          cnt_req_d = snap[pick_ch];
          req_d     = 1'b1;
          wait_d    = '0;
          ptr_d     = (pick_ch == CH_LAST) ? '0 : pick_ch + 1'b1;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (scale_ack) begin
          rpm_d[ch_q]       = scale_rpm;
          rpm_valid_d[ch_q] = 1'b1;
          pending_d[ch_q]   = 1'b0;
          req_d             = 1'b0;
          state_d           = S_IDLE;
        end else if (wait_q == TMO_LAST) begin
          tmo_d[ch_q]     = 1'b1;
          pending_d[ch_q] = 1'b0;
          req_d           = 1'b0;
          state_d         = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a fresh snapshot re-arms every channel; an ack on the same cycle is not an overrun
    for (int k = 0; k < NCH; k++) begin
      if (term) begin
        pending_d[k] = 1'b1;
        if (pending_q[k] && !(ack_hit && ch_q == CH_W'(k))) overrun_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      wait_q      <= '0;
      ptr_q       <= '0;
      ch_q        <= '0;
      cnt_req_q   <= '0;
      req_q       <= 1'b0;
      pending_q   <= '0;
      overrun_q   <= '0;
      tmo_q       <= '0;
      rpm_valid_q <= '0;
      rpm_q       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wait_q      <= wait_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      cnt_req_q   <= cnt_req_d;
      req_q       <= req_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      tmo_q       <= tmo_d;
      rpm_valid_q <= rpm_valid_d;
      rpm_q       <= rpm_d;
    end
  end

  assign scale_req = req_q;
  assign scale_ch  = ch_q;
  assign scale_cnt = cnt_req_q;
  assign rpm       = rpm_q;
  assign rpm_valid = rpm_valid_q;
  assign overrun   = overrun_q;
  assign tmo_err   = tmo_q;
endmodule

// File: tb/tb_encoder_rpm_sched.sv
// Bench: dut A (CNT_W=16, TIMEOUT=16) and dut B (CNT_W=4, TIMEOUT=400), both on
// a 100-cycle gate; a muxed scaler responder serves whichever one is selected.

module tb_encoder_rpm_sched;
  localparam int GATE  = 100;
  localparam int RPM_W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bit         sel_b    = 1'b0;
  logic [3:0] tick_drv = '0;
  logic       ack_drv  = 1'b0;
  logic [9:0] rpm_drv  = '0;

  logic [3:0]  ticks_a, ticks_b, rv_a, rv_b, ovr_a, ovr_b, tmo_a, tmo_b;
  logic        req_a, req_b, ack_a, ack_b;
  logic [1:0]  ch_a, ch_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [39:0] rpm_a, rpm_b;

  assign ticks_a = sel_b ? 4'b0 : tick_drv;
  assign ticks_b = sel_b ? tick_drv : 4'b0;
  assign ack_a   = ack_drv & ~sel_b;
  assign ack_b   = ack_drv & sel_b;

  logic        req_m;
  logic [1:0]  ch_m;
  logic [15:0] cnt_m;
  logic [39:0] rpm_mo;
  logic [3:0]  rv_m, ovr_m, tmo_m;
  assign req_m  = sel_b ? req_b : req_a;
  assign ch_m   = sel_b ? ch_b : ch_a;
  assign cnt_m  = sel_b ? {12'd0, cnt_b} : cnt_a;
  assign rpm_mo = sel_b ? rpm_b : rpm_a;
  assign rv_m   = sel_b ? rv_b : rv_a;
  assign ovr_m  = sel_b ? ovr_b : ovr_a;
  assign tmo_m  = sel_b ? tmo_b : tmo_a;

  encoder_rpm_sched #(.NCH(4), .GATE_CYCLES(GATE), .CNT_W(16), .RPM_W(RPM_W), .TIMEOUT(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ticks(ticks_a), .scale_req(req_a), .scale_ch(ch_a),
    .scale_cnt(cnt_a), .scale_ack(ack_a), .scale_rpm(rpm_drv), .rpm(rpm_a),
    .rpm_valid(rv_a), .overrun(ovr_a), .tmo_err(tmo_a)
  );

  encoder_rpm_sched #(.NCH(4), .GATE_CYCLES(GATE), .CNT_W(4), .RPM_W(RPM_W), .TIMEOUT(400)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ticks(ticks_b), .scale_req(req_b), .scale_ch(ch_b),
    .scale_cnt(cnt_b), .scale_ack(ack_b), .scale_rpm(rpm_drv), .rpm(rpm_b),
    .rpm_valid(rv_b), .overrun(ovr_b), .tmo_err(tmo_b)
  );

  // cycles since reset release; equals the gate phase of both duts
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int rpm_exp [4];

  typedef struct packed {
    logic [3:0][7:0]  edges;
    logic [7:0]       dly;
    logic [3:0][9:0]  rpmv;
    logic [3:0][15:0] exp_cnt;
    logic [39:0]      exp_rpm;
  } vec_t;
  vec_t tbl [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] pack_rpm();
    logic [39:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*RPM_W +: RPM_W] = rpm_exp[k][9:0];
    return v;
  endfunction

  task automatic wait_phase(input int p);
    int t;
    t = 0;
    while ((cyc % GATE) != p && t < 3*GATE) begin
      @(negedge clk);
      t++;
    end
    chk("phase_wait", t < 3*GATE, 1);
  endtask

  task automatic drive_edges(input logic [3:0][7:0] e);
    int mx;
    mx = 0;
    for (int k = 0; k < 4; k++) if (int'(e[k]) > mx) mx = int'(e[k]);
    for (int r = 0; r < mx; r++) begin
      for (int k = 0; k < 4; k++) tick_drv[k] = (int'(e[k]) > r);
      @(negedge clk);
      tick_drv = '0;
      @(negedge clk);
    end
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    while (!req_m && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", req_m, 1);
  endtask

  task automatic serve(input int dly, input int r, input int exp_ch, input int exp_cnt);
    wait_req();
    chk("scale_ch", ch_m, exp_ch);
    chk("scale_cnt", cnt_m, exp_cnt);
    repeat (dly) @(negedge clk);
    ack_drv = 1'b1;
    rpm_drv = r[9:0];
    @(negedge clk);
    ack_drv = 1'b0;
    chk("rpm_slice", rpm_mo[exp_ch*RPM_W +: RPM_W], r);
    chk("rpm_valid", rv_m, 1 << exp_ch);
    chk("req_drop", req_m, 0);
    if (!sel_b) rpm_exp[exp_ch] = r;
    @(negedge clk);
    chk("rpm_valid_pulse", rv_m, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][7:0] e;
    int dly, hi;
    int rv [4];

    for (int k = 0; k < 4; k++) rpm_exp[k] = 0;
    tbl[0] = '{edges: {8'd0, 8'd0, 8'd0, 8'd4}, dly: 8'd3,
               rpmv: {10'd0, 10'd0, 10'd0, 10'd240},
               exp_cnt: {16'd0, 16'd0, 16'd0, 16'd4},
               exp_rpm: {10'd0, 10'd0, 10'd0, 10'd240}};
    tbl[1] = '{edges: {8'd4, 8'd3, 8'd2, 8'd1}, dly: 8'd0,
               rpmv: {10'd240, 10'd180, 10'd120, 10'd60},
               exp_cnt: {16'd4, 16'd3, 16'd2, 16'd1},
               exp_rpm: {10'd240, 10'd180, 10'd120, 10'd60}};
    tbl[2] = '{edges: {8'd7, 8'd0, 8'd5, 8'd0}, dly: 8'd2,
               rpmv: {10'd1023, 10'd3, 10'd2, 10'd1},
               exp_cnt: {16'd7, 16'd0, 16'd5, 16'd0},
               exp_rpm: {10'd1023, 10'd3, 10'd2, 10'd1}};

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", req_a, 0);
    chk("rst_ch", ch_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_rpm", rpm_a, 0);
    chk("rst_flags", {rv_a, ovr_a, tmo_a}, 0);
    chk("rst_req_b", req_b, 0);
    @(negedge clk);
    @(negedge clk);
    sel_b = 1'b1;
    rst_n = 1'b1;

    // dut B: 20 edges on ch1 saturate a 4-bit counter at 15
    wait_phase(45);
    e = {8'd0, 8'd0, 8'd20, 8'd0};
    drive_edges(e);
    serve(0, 0, 0, 0);
    serve(0, 100, 1, 15);
    serve(0, 0, 2, 0);
    serve(0, 0, 3, 0);

    // dut B: ch2 request held across a terminal cycle
    wait_phase(45);
    e = {8'd0, 8'd3, 8'd0, 8'd0};
    drive_edges(e);
    serve(0, 0, 0, 0);
    serve(0, 0, 1, 0);
    wait_req();
    chk("b_hold_ch", ch_m, 2);
    chk("b_hold_cnt", cnt_m, 3);
    wait_phase(45);
    e = {8'd0, 8'd5, 8'd0, 8'd0};
    drive_edges(e);
    wait_phase(10);
    chk("b_still_req", req_m, 1);
    chk("b_cnt_stable", cnt_m, 3);
    chk("b_overrun", ovr_m, 4'b1100);
    chk("b_no_tmo", tmo_m, 0);
    serve(0, 77, 2, 3);

    // reset again and switch to dut A
    rst_n = 1'b0;
    @(negedge clk);
    sel_b = 1'b0;
    chk("rst2_ovr", ovr_a, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 3; v++) begin
      wait_phase(45);
      drive_edges(tbl[v].edges);
      for (int k = 0; k < 4; k++)
        serve(int'(tbl[v].dly), int'(tbl[v].rpmv[k]), k, int'(tbl[v].exp_cnt[k]));
      chk("tbl_rpm", rpm_a, tbl[v].exp_rpm);
    end

    // random windows against the model: every channel snapshotted and served 0..3
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 4; k++) begin
        e[k]  = 8'($urandom_range(0, 12));
        rv[k] = int'($urandom_range(0, 1023));
      end
      dly = int'($urandom_range(0, 4));
      wait_phase(45);
      drive_edges(e);
      for (int k = 0; k < 4; k++) serve(dly, rv[k], k, int'(e[k]));
      chk("rand_rpm", rpm_a, pack_rpm());
    end
    chk("a_no_overrun", ovr_a, 0);
    chk("a_no_tmo", tmo_a, 0);

    // timeout on ch0: request lasts 16 cycles, then ch1 is served
    wait_phase(45);
    e = {8'd1, 8'd1, 8'd1, 8'd1};
    drive_edges(e);
    wait_req();
    chk("tmo_ch", ch_a, 0);
    chk("tmo_cnt", cnt_a, 1);
    hi = 0;
    while (req_a && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    chk("tmo_len", hi, 16);
    chk("tmo_err", tmo_a, 4'b0001);
    chk("tmo_rv", rv_a, 0);
    chk("tmo_rpm", rpm_a, pack_rpm());
    serve(1, 300, 1, 1);
    serve(1, 301, 2, 1);
    serve(1, 302, 3, 1);
    chk("tmo_sticky", tmo_a, 4'b0001);

    // reset mid-BUSY
    wait_phase(45);
    e = {8'd2, 8'd2, 8'd2, 8'd2};
    drive_edges(e);
    wait_req();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", req_a, 0);
    chk("mid_rst_ch_cnt", {ch_a, cnt_a}, 0);
    chk("mid_rst_rpm", rpm_a, 0);
    chk("mid_rst_flags", {rv_a, ovr_a, tmo_a}, 0);
    for (int k = 0; k < 4; k++) rpm_exp[k] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_phase(45);
    e = {8'd0, 8'd3, 8'd0, 8'd0};
    drive_edges(e);
    serve(0, 11, 0, 0);
    serve(0, 12, 1, 0);
    serve(0, 13, 2, 3);
    serve(0, 14, 3, 0);
    chk("post_rst_rpm", rpm_a, pack_rpm());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
